// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Bubbles present inert control (all zero) and a NOP instruction word.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W    = 64,
    parameter int unsigned          NUM_DATA  = 3,
    parameter int unsigned          CTRL_W    = 11,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'hD503201F)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_DATA*DATA_W-1:0]    data_in,
    input  logic [CTRL_W-1:0]             ctrl_in,
    input  logic [INSTR_W-1:0]            instr_in,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_DATA*DATA_W-1:0]    data_out,
    output logic [CTRL_W-1:0]             ctrl_out,
    output logic [INSTR_W-1:0]            instr_out,
    output logic [1:0]                    occupancy
);

    localparam int unsigned LANES_W = NUM_DATA * DATA_W;

    // Main entry M: valid is out_valid, data is data_out; ctrl/instr kept raw here.
    logic [CTRL_W-1:0]  m_ctrl;
    logic [INSTR_W-1:0] m_instr;

    // Skid entry S
    logic               s_valid;
    logic [LANES_W-1:0] s_data;
    logic [CTRL_W-1:0]  s_ctrl;
    logic [INSTR_W-1:0] s_instr;

    logic               accept;
    logic               take;
    logic               m_valid_n;
    logic               s_valid_n;
    logic [LANES_W-1:0] m_data_n;
    logic [CTRL_W-1:0]  m_ctrl_n;
    logic [INSTR_W-1:0] m_instr_n;
    logic [LANES_W-1:0] s_data_n;
    logic [CTRL_W-1:0]  s_ctrl_n;
    logic [INSTR_W-1:0] s_instr_n;

    // Next-state for the two entries; flush drops valids but leaves payload untouched.
    always_comb begin
        accept    = in_valid & in_ready;
        take      = out_valid & out_ready;
        m_valid_n = out_valid;
        s_valid_n = s_valid;
        m_data_n  = data_out;
        m_ctrl_n  = m_ctrl;
        m_instr_n = m_instr;
        s_data_n  = s_data;
        s_ctrl_n  = s_ctrl;
        s_instr_n = s_instr;

        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (s_valid) begin
            if (take) begin
                m_data_n  = s_data;
                m_ctrl_n  = s_ctrl;
                m_instr_n = s_instr;
                s_valid_n = 1'b0;
            end
        end else if (out_valid) begin
            if (accept && take) begin
                m_data_n  = data_in;
                m_ctrl_n  = ctrl_in;
                m_instr_n = instr_in;
            end else if (accept) begin
                s_data_n  = data_in;
                s_ctrl_n  = ctrl_in;
                s_instr_n = instr_in;
                s_valid_n = 1'b1;
            end else if (take) begin
                m_valid_n = 1'b0;
            end
        end else if (accept) begin
            m_data_n  = data_in;
            m_ctrl_n  = ctrl_in;
            m_instr_n = instr_in;
            m_valid_n = 1'b1;
        end
    end

    // Storage plus registered status and bubble-masked outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
            data_out  <= '0;
            m_ctrl    <= '0;
            m_instr   <= '0;
            s_data    <= '0;
            s_ctrl    <= '0;
            s_instr   <= '0;
            in_ready  <= 1'b1;
            ctrl_out  <= '0;
            instr_out <= NOP_INSTR;
            occupancy <= 2'd0;
        end else begin
            out_valid <= m_valid_n;
            s_valid   <= s_valid_n;
            data_out  <= m_data_n;
            m_ctrl    <= m_ctrl_n;
            m_instr   <= m_instr_n;
            s_data    <= s_data_n;
            s_ctrl    <= s_ctrl_n;
            s_instr   <= s_instr_n;
            in_ready  <= ~s_valid_n;
            ctrl_out  <= m_valid_n ? m_ctrl_n : '0;
            instr_out <= m_valid_n ? m_instr_n : NOP_INSTR;
            occupancy <= 2'(m_valid_n) + 2'(s_valid_n);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage CPU. It generalises the fixed RF/EX latch to N data lanes plus a control vector and an instruction word. It adds a valid/ready handshake, a 2-entry skid buffer for stalls, a flush that injects a bubble, and guaranteed-inert control outputs during bubbles. One instance is placed between each pair of stages (IF/RF, RF/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 64, width of each data lane
NUM_DATA, 3, number of data lanes (e.g. data_a, data_b, norm_result)
CTRL_W, 11, width of packed control vector (isADDI, MemWrite, ALUSrc, flag_en, read_en, RegWrite, Reg3Loc, MemToReg[1:0], ALUop… per instance)
INSTR_W, 32, instruction word width
NOP_INSTR, 32'hD503201F, instruction value presented during bubbles

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  upstream stage has a valid entry
in_ready  out  1  this stage can accept; registered, no combinational path from out_ready
data_in  in  NUM_DATA*DATA_W  packed data lanes, lane k = bits [k*DATA_W +: DATA_W]
ctrl_in  in  CTRL_W  control vector
instr_in  in  INSTR_W  instruction word
flush  in  1  discard all held entries (branch mispredict / exception)
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts this cycle
data_out  out  NUM_DATA*DATA_W  held data lanes
ctrl_out  out  CTRL_W  held control; forced 0 when out_valid=0
instr_out  out  INSTR_W  held instruction; NOP_INSTR when out_valid=0
occupancy  out  2  number of held entries, 0..2 (debug/perf)

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each holding {data, ctrl, instr} plus a valid bit.
- accept = in_valid & in_ready. take = out_valid & out_ready.
- in_ready = ~S.valid (registered).
- out_valid = M.valid.
- States by occupancy:
  - EMPTY: accept -> ONE, M<=in.
  - ONE: accept&take -> ONE, M<=in. accept only -> FULL, S<=in. take only -> EMPTY.
  - FULL: in_ready=0. take -> ONE, M<=S, S cleared. No take -> hold.
- Latency: 1 cycle from accept into an empty stage to out_valid=1.
- Throughput: 1 entry per cycle while out_ready=1. Strict FIFO order, no drop, no duplication.
- Bubble outputs: when out_valid=0, ctrl_out=0 and instr_out=NOP_INSTR; data_out holds its last value.
- flush=1 at a clock edge:
  - Next cycle: M.valid=S.valid=0, occupancy=0, in_ready=1.
  - flush overrides a simultaneous accept (the input is discarded) and a simultaneous take (downstream still sampled the entry that cycle).
- reset=0 at a clock edge:
  - Same as flush, plus all data, ctrl and instr storage cleared to 0.
  - Outputs after reset: out_valid=0, in_ready=1, ctrl_out=0, instr_out=NOP_INSTR, data_out=0, occupancy=0.
  - Reset dominates flush and all handshakes, including mid-stall with FULL occupancy.
- Degenerate parameters: NUM_DATA=1 and CTRL_W=1 must be legal. No arithmetic on payload; widths pass through unchanged.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, ctrl_out=0, instr_out=NOP_INSTR, occupancy=0; first rising edge after release with in_valid=1 accepts.
- Streaming: out_ready=1, push instr 0x8B020020, 0x91000421, 0xF8400062 on consecutive cycles -> same sequence on instr_out, 1-cycle delayed, out_valid continuously 1, occupancy=1.
- Stall: out_ready=0, push A, B, C -> A, B held (occupancy=2), in_ready=0 on the cycle C is presented, C not accepted. Raise out_ready -> A, B, then C in order, no loss.
- Flush while FULL with simultaneous in_valid: next cycle out_valid=0, occupancy=0, ctrl_out=0 (RegWrite/MemWrite bits 0), instr_out=NOP_INSTR; the flushed input never appears.
- Data lanes: NUM_DATA=3, lanes 64'hDEADBEEF_00000001 / 64'h1 / 64'hFFFF_FFFF_FFFF_FFFF -> each appears in the correct bit slice of data_out. Repeat with DATA_W=32, NUM_DATA=1.
- Reset while FULL and out_ready=1: all valids clear on the next edge, no entry emitted after the reset edge, data_out=0.
